bip_debug_sequencer: RTL
========================

# bip_debug_sequencer

Controls the BIP accumulator CPU's halt and debug dump. While the CPU runs, it counts executed cycles. When the instruction decoder flags HLT (its `wr_uart` output), it freezes the CPU, takes a snapshot of PC, ACC and the cycle count, and sends them as a fixed 9-byte frame through the UART transmitter using a start/done handshake. It sits between the instruction decoder, the PC/ACC datapath and the UART TX.

## Interface
- `PC_W`, default 11: program counter width; must be ≤ 16.
- `DATA_W`, default 16: accumulator width; must be ≤ 16.
- `CNT_W`, default 32: cycle counter width; must be ≤ 32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset; one clock domain only.
- `halt`  in  1  HLT decoded (decoder `wr_uart`); level, combinational from opcode.
- `pc`  in  PC_W  current program counter.
- `acc`  in  DATA_W  current accumulator value.
- `tx_done`  in  1  one-cycle pulse from UART TX when a byte is fully sent.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_data`  out  8  byte to transmit; stable from `tx_start` until the matching `tx_done`.
- `cpu_en`  out  1  gates the WrPC/WrAcc/WrRam write enables; 1 while running.
- `busy`  out  1  frame transmission in progress.
- `done`  out  1  frame fully sent; CPU is parked.

## Operation
- **States:** RUN, LOAD, WAIT, DONE.
- **RUN**
  - `cpu_en` = 1.
  - The cycle counter increments on each edge where `halt` = 0.
  - The counter saturates at 2^CNT_W − 1 and never wraps.
- **RUN → LOAD** when `halt` = 1. On the same edge:
  - Snapshot `cnt`, `pc`, `acc` into internal registers.
  - Set byte index = 0 and `cpu_en` = 0.
  - The HLT cycle itself is not counted.
- **Frame content**, byte order:
  - 0: 0xA5
  - 1–4: count, zero-extended to 32 bits, MSB first
  - 5–6: pc, zero-extended to 16 bits, MSB first
  - 7–8: acc, zero-extended to 16 bits, MSB first
- **LOAD**: drive `tx_data` = frame[idx] and `tx_start` = 1 for exactly one cycle, then go to WAIT.
- **WAIT** on `tx_done`:
  - If idx = 8, go to DONE.
  - Otherwise increment idx and go to LOAD.
- **DONE**: absorbing state; only `reset` leaves it. `halt` is ignored here, so no retransmission occurs.
- `tx_done` is ignored in RUN, LOAD and DONE.
- `halt` is ignored outside RUN.
- The snapshot registers do not change after capture; input changes during transmission have no effect.
- **Reset**, at any time including mid-frame:
  - Return to RUN; count = 0, idx = 0.
  - `tx_start` = 0 immediately.
  - Any byte already handed to the UART is abandoned; there is no resume.

## Timing
- **Reset values:** `cpu_en` = 1, `tx_start` = 0, `tx_data` = 0x00, `busy` = 0, `done` = 0.
- All outputs are registered. None depends combinationally on `halt` or `tx_done`.
- **Halt:** `halt` high at edge N gives `cpu_en` = 0 and `busy` = 1 after edge N. `tx_start` pulses after edge N+1.
- **Next byte:** `tx_done` at edge M gives the next `tx_start` after edge M+1. Minimum spacing between starts is therefore 3 cycles.
- **Frame end:** `done` = 1 and `busy` = 0 after the edge that samples the 9th `tx_done`.
- **`busy`** = 1 in LOAD and WAIT only.
- **Overlap:** if `tx_done` arrives in the same cycle as `tx_start` is high, it is ignored, because LOAD does not sample it.

## Structure
- Package `bip_dbg_pkg`:
  - state enum (RUN/LOAD/WAIT/DONE)
  - `FRAME_LEN` = 9
  - `FRAME_HDR` = 8'hA5
  - byte-offset constants for the count, PC and ACC fields
- Sub-module `bip_cycle_counter`:
  - inputs: `clk`, `reset`, `en`
  - output: `cnt`
  - parameter `CNT_W`; saturating counter.
- The top level holds the FSM, snapshot registers and frame byte mux.

## Test plan
- **Normal frame:** reset, then 10 cycles with `halt` = 0, then `halt` = 1 with `pc` = 0x00A and `acc` = 0x1234. `tx_done` is returned 3 cycles after each `tx_start`.
  - Required bytes: A5 00 00 00 0A 00 0A 12 34.
  - `done` = 1 one cycle after the 9th `tx_done`.
- **Saturation:** `CNT_W` = 4, 20 run cycles, then halt. Count bytes must be 00 00 00 0F.
- **Input stability:** change `pc`/`acc` and pulse spurious `tx_done` in RUN and LOAD during the frame.
  - Frame bytes are unchanged.
  - Exactly 9 `tx_start` pulses, each one cycle wide.
- **Reset mid-frame:** assert `reset` after byte 4.
  - `tx_start` = 0, `busy` = 0, `cpu_en` = 1 immediately.
  - After release with 3 cycles then halt, a new frame carries count = 3.
- **No retransmit:** hold `halt` = 1 for 50 cycles after DONE. No further `tx_start`; `done` stays 1.
- **Halt at first cycle:** `halt` = 1 in the first cycle after reset release. Count field = 00 00 00 00.

Source files
------------

// File: rtl/bip_dbg_pkg.sv
// bip_dbg_pkg
//   Shared definitions for the BIP halt/debug-dump sequencer:
//   FSM state type, debug frame layout constants and the frame byte
//   selector used by the top level.
package bip_dbg_pkg;

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        WAIT,
        DONE
    } dbgState_t;

    // Frame layout: header, 32-bit count, 16-bit PC, 16-bit ACC, all MSB first.
    localparam int unsigned FRAME_LEN = 9;
    localparam logic [7:0]  FRAME_HDR = 8'hA5;

    localparam logic [3:0]  HDR_OFS  = 4'd0;
    localparam logic [3:0]  CNT_OFS  = 4'd1;
    localparam logic [3:0]  PC_OFS   = 4'd5;
    localparam logic [3:0]  ACC_OFS  = 4'd7;
    localparam logic [3:0]  LAST_IDX = 4'(FRAME_LEN - 1);

    // Select byte idx of the frame from the already zero-extended fields.
    function automatic logic [7:0] frameByte(
        input logic [3:0]  idx,
        input logic [31:0] cntVal,
        input logic [15:0] pcVal,
        input logic [15:0] accVal
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            HDR_OFS:          b = FRAME_HDR;
            CNT_OFS:          b = cntVal[31:24];
            CNT_OFS + 4'd1:   b = cntVal[23:16];
            CNT_OFS + 4'd2:   b = cntVal[15:8];
            CNT_OFS + 4'd3:   b = cntVal[7:0];
            PC_OFS:           b = pcVal[15:8];
            PC_OFS + 4'd1:    b = pcVal[7:0];
            ACC_OFS:          b = accVal[15:8];
            ACC_OFS + 4'd1:   b = accVal[7:0];
            default:          b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bip_cycle_counter.sv
// bip_cycle_counter
//   Saturating cycle counter: increments on each enabled rising edge and
//   sticks at all-ones instead of wrapping.
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset, clears the count
//     en     count enable for this edge
//     cnt    current count
module bip_cycle_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bip_debug_sequencer.sv
// bip_debug_sequencer
//   Halt controller and debug dumper for the BIP accumulator CPU. Counts
//   executed cycles while running; on HLT it parks the CPU, snapshots the
//   cycle count, PC and ACC, and streams a 9-byte frame to the UART TX
//   using a start/done handshake. After the frame it stays parked until reset.
//   Ports:
//     clk       system clock
//     reset     asynchronous active-high reset
//     halt      HLT decoded by the instruction decoder (level)
//     pc        current program counter
//     acc       current accumulator
//     tx_done   one-cycle pulse from UART TX, byte fully sent
//     tx_start  one-cycle pulse requesting transmission of tx_data
//     tx_data   byte to transmit, held until the matching tx_done
//     cpu_en    CPU write enable gate, high while running
//     busy      frame transmission in progress
//     done      frame fully sent, CPU parked
module bip_debug_sequencer
    import bip_dbg_pkg::*;
#(
    parameter int unsigned PC_W   = 11,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] acc,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              cpu_en,
    output logic              busy,
    output logic              done
);

    dbgState_t        state;
    logic [3:0]       byteIdx;
    logic [31:0]      snapCnt;
    logic [15:0]      snapPc;
    logic [15:0]      snapAcc;
    logic [CNT_W-1:0] cycleCnt;
    logic             cntEn;

    // The HLT cycle itself is not counted, and counting stops once parked.
    assign cntEn = (state == RUN) && !halt;

    bip_cycle_counter #(
        .CNT_W (CNT_W)
    ) uCycleCounter (
        .clk   (clk),
        .reset (reset),
        .en    (cntEn),
        .cnt   (cycleCnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            byteIdx  <= '0;
            snapCnt  <= '0;
            snapPc   <= '0;
            snapAcc  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            cpu_en   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        snapCnt <= 32'(cycleCnt);
                        snapPc  <= 16'(pc);
                        snapAcc <= 16'(acc);
                        byteIdx <= '0;
                        cpu_en  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end

                LOAD: begin
                    tx_data  <= frameByte(byteIdx, snapCnt, snapPc, snapAcc);
                    tx_start <= 1'b1;
                    state    <= WAIT;
                end

                WAIT: begin
                    tx_start <= 1'b0;
                    // While tx_start is still high the byte has only just been
                    // requested, so a tx_done in that cycle cannot be its
                    // completion and is dropped.
                    if (tx_done && !tx_start) begin
                        if (byteIdx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            byteIdx <= byteIdx + 4'd1;
                            state   <= LOAD;
                        end
                    end
                end

                DONE: begin
                    // Parked until reset; halt and tx_done have no effect.
                    tx_start <= 1'b0;
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
